hazard_scheduler: RTL
=====================

// Module: hazard_scheduler
// PURPOSE
//  Pipeline hazard scheduler for the 5-stage MIPS core. Sits beside the ID-stage controller.
//  Decides stall/flush per cycle from ID/EX/MEM/WB register fields and branch/jump resolution.
//  Sequences the multi-cycle MDU (mult/div) so HI/LO reads and new MDU ops wait until the result is ready.
//  Drives EX-stage operand-forwarding selects.
// PARAMETERS
//  MDU_LATENCY  32  cycles from MDU start to result valid (>=2)
//  REG_AW       5   register-address width
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       synchronous, active-high
//  id_rs,id_rt    in   REG_AW  ID-stage source registers
//  id_uses_rs/rt  in   1       ID instruction reads rs / rt
//  id_branch      in   1       beq|bne in ID (controller outputbranch)
//  id_pcsrc       in   2       controller pcsrc {jump, branch_taken}
//  id_mdu_start   in   1       ID holds mult/div
//  id_mdu_read    in   1       ID holds mfhi/mflo
//  ex_rs,ex_rt    in   REG_AW  EX-stage source registers
//  ex_rd          in   REG_AW  EX destination; ex_regwrite, ex_memread in 1 each
//  mem_rd         in   REG_AW  MEM destination; mem_regwrite, mem_memread in 1 each
//  wb_rd          in   REG_AW  WB destination; wb_regwrite in 1
//  stall_if       out  1       hold PC
//  stall_id       out  1       hold IF/ID register
//  flush_id       out  1       clear IF/ID (squash wrong-path fetch)
//  flush_ex       out  1       insert bubble into ID/EX
//  fwd_a,fwd_b    out  2       EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  mdu_busy       out  1       MDU sequencer not IDLE
// BEHAVIOUR
//  - Match(x,r) = x!=0 && x==r. Register 0 never causes a hazard or forward.
//  - Load-use: ex_memread && ex_rd matches a used ID source -> stall.
//  - Branch in ID: id_branch && ex_regwrite && ex_rd matches rs/rt -> stall.
//    Branch in ID: id_branch && mem_memread && mem_rd matches rs/rt -> stall.
//  - MDU: (id_mdu_start|id_mdu_read) while state==BUSY -> stall.
//  - stall => stall_if=stall_id=flush_ex=1 in the same cycle (combinational).
//  - flush_id = |id_pcsrc & ~stall. A stall suppresses the flush; the branch re-resolves next cycle.
//  - MDU FSM (registered):
//      IDLE -start&~stall-> BUSY, cnt<=MDU_LATENCY-1
//      BUSY: cnt-- ; cnt==1 -> DONE
//      DONE -> IDLE, or -> BUSY if start accepted this cycle
//      A read in DONE or IDLE is not stalled.
//  - mdu_busy = (state==BUSY). cnt is REG-width $clog2(MDU_LATENCY); it never wraps (held at 0 in IDLE).
//  - Reset, including mid-BUSY: state=IDLE, cnt=0. All outputs 0 while reset is high and the cycle after.
//  - Combinational outputs depend only on current inputs plus FSM state; no input-to-output latency.
// CONFIGURATION
//  FORWARD_EN defined: forward selection, EX/MEM priority over MEM/WB.
//    fwd_a=10 if mem_regwrite & Match(ex_rs,mem_rd); else 01 if wb_regwrite & Match(ex_rs,wb_rd); fwd_b likewise with ex_rt.
//    Stall only on the load-use, branch and MDU rules.
//  FORWARD_EN undefined: fwd_a=fwd_b=00 always.
//    Additionally stall whenever ex_regwrite or mem_regwrite targets a used ID source.
//    The regfile writes in the first half-cycle, so WB does not stall.
// STRUCTURE
//  pipeline_pkg: FWD_RF/FWD_EXMEM/FWD_MEMWB constants; mdu_state_t {IDLE,BUSY,DONE}.
//  Sub-module mdu_sequencer holds the FSM and counter.
//  Top holds the comparators and the stall/flush/forward logic.
// TESTING
//  1. lw $8 in EX, add $9,$8,$1 in ID -> stall_if=stall_id=flush_ex=1 one cycle, then 0.
//  2. beq $3,$4 in ID, ex_rd=3 ex_regwrite -> stall one cycle.
//     Next cycle pcsrc=01 -> flush_id=1, stall=0.
//  3. mult start, MDU_LATENCY=4 -> mdu_busy high 3 cycles.
//     mfhi in ID stalls during BUSY and is released in DONE.
//  4. FORWARD_EN: ex_rs=5, mem_rd=5, wb_rd=5, both regwrite -> fwd_a=10.
//     ex_rd=0 load-use with rs=0 -> no stall.
//  5. No FORWARD_EN: mem_regwrite mem_rd=7, ID uses rt=7 -> stall, fwd_b=00.
//  6. reset asserted mid-BUSY -> next cycle mdu_busy=0, all outputs 0; new start accepted after.

Source files
------------

// File: rtl/hazard_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scheduler_pkg
// Shared definitions for the hazard scheduler:
//   FWD_RF / FWD_EXMEM / FWD_MEMWB : EX operand-forwarding select encodings
//   mdu_state_t                    : MDU sequencer states {IDLE, BUSY, DONE}
// ---------------------------------------------------------------------------
package hazard_scheduler_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_EXMEM = 2'b10;  // operand from EX/MEM pipeline register
  localparam logic [1:0] FWD_MEMWB = 2'b01;  // operand from MEM/WB pipeline register

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/hazard_scheduler_if.sv
// ---------------------------------------------------------------------------
// hazard_scheduler_if
// Bundles the pipeline-side fields the scheduler observes and the
// stall/flush/forward controls it returns.
//   master : pipeline side (drives ID/EX/MEM/WB fields, receives controls)
//   slave  : scheduler side (reads fields, drives controls)
// Parameter REG_AW : register-address width.
// ---------------------------------------------------------------------------
interface hazard_scheduler_if #(
  parameter int REG_AW = 5
);
  // ID stage
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_branch;
  logic [1:0]        id_pcsrc;
  logic              id_mdu_start;
  logic              id_mdu_read;
  // EX stage
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  // MEM stage
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic              mem_memread;
  // WB stage
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  // Scheduler controls
  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              flush_ex;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mdu_busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_pcsrc,
           id_mdu_start, id_mdu_read,
           ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, mem_memread,
           wb_rd, wb_regwrite,
    input  stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, mdu_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch, id_pcsrc,
           id_mdu_start, id_mdu_read,
           ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
           mem_rd, mem_regwrite, mem_memread,
           wb_rd, wb_regwrite,
    output stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, mdu_busy
  );

endinterface

// File: rtl/hazard_scheduler_mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer
// Tracks the multi-cycle multiply/divide unit. An accepted start moves the
// FSM to BUSY for MDU_LATENCY-1 cycles, then DONE for one cycle (result
// readable), then IDLE unless a new start is accepted in DONE.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; forces IDLE, counter 0
//   start_i  in   MDU start accepted this cycle (already qualified by stall)
//   state_o  out  current sequencer state
// Parameter MDU_LATENCY : cycles from start to result valid (>= 2).
// ---------------------------------------------------------------------------
module mdu_sequencer
  import hazard_scheduler_pkg::*;
#(
  parameter int MDU_LATENCY = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  output mdu_state_t state_o
);

  localparam int              CNT_W    = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        // Guarded decrement keeps the counter from wrapping.
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/hazard_scheduler.sv
// ---------------------------------------------------------------------------
// hazard_scheduler
// Hazard scheduler for the 5-stage MIPS core. Each cycle it decides whether
// the ID instruction must stall (load-use, branch operand not yet available,
// MDU busy), whether the wrong-path fetch in IF/ID must be flushed, and which
// source the EX operands take.
// Ports:
//   clk    in      clock, rising edge
//   reset  in      synchronous, active-high
//   bus    slave   hazard_scheduler_if: ID/EX/MEM/WB fields in,
//                  stall_if/stall_id/flush_id/flush_ex/fwd_a/fwd_b/mdu_busy out
// Configuration macro FORWARD_EN:
//   defined   - EX/MEM and MEM/WB forwarding (EX/MEM has priority); stalls
//               only on load-use, branch and MDU hazards.
//   undefined - no forwarding (selects stay 00); additionally stalls while
//               EX or MEM is still to write a register ID reads.
// All outputs are held at 0 while reset is high and for the cycle after.
// ---------------------------------------------------------------------------
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int REG_AW      = 5
) (
  input  logic             clk,
  input  logic             reset,
  hazard_scheduler_if.slave bus
);

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_AW-1:0] x,
                                     input logic [REG_AW-1:0] r);
    return (x != '0) && (x == r);
  endfunction

  mdu_state_t mdu_state;
  logic       mask_q;
  logic       out_en;
  logic       mdu_busy_raw;
  logic       hit_ex, hit_mem;
  logic       br_ex, br_mem;
  logic       stall_load, stall_branch, stall_mdu, stall_raw, stall;
  logic       start_acc;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  // One-cycle tail after reset during which every output stays quiet.
  always_ff @(posedge clk) begin
    mask_q <= reset;
  end

  assign out_en = ~(reset | mask_q);

  // A used ID source is produced by the instruction in EX / MEM.
  assign hit_ex  = (bus.id_uses_rs & reg_match(bus.id_rs, bus.ex_rd)) |
                   (bus.id_uses_rt & reg_match(bus.id_rt, bus.ex_rd));
  assign hit_mem = (bus.id_uses_rs & reg_match(bus.id_rs, bus.mem_rd)) |
                   (bus.id_uses_rt & reg_match(bus.id_rt, bus.mem_rd));

  // Branches compare in ID, so both operands must be final there.
  assign br_ex  = reg_match(bus.id_rs, bus.ex_rd)  | reg_match(bus.id_rt, bus.ex_rd);
  assign br_mem = reg_match(bus.id_rs, bus.mem_rd) | reg_match(bus.id_rt, bus.mem_rd);

  assign mdu_busy_raw = (mdu_state == BUSY);

  assign stall_load   = bus.ex_memread & hit_ex;
  assign stall_branch = bus.id_branch &
                        ((bus.ex_regwrite & br_ex) | (bus.mem_memread & br_mem));
  assign stall_mdu    = (bus.id_mdu_start | bus.id_mdu_read) & mdu_busy_raw;

`ifdef FORWARD_EN
  assign stall_raw = stall_load | stall_branch | stall_mdu;

  always_comb begin
    fwd_a_raw = FWD_RF;
    fwd_b_raw = FWD_RF;
    if (bus.mem_regwrite & reg_match(bus.ex_rs, bus.mem_rd))
      fwd_a_raw = FWD_EXMEM;
    else if (bus.wb_regwrite & reg_match(bus.ex_rs, bus.wb_rd))
      fwd_a_raw = FWD_MEMWB;
    if (bus.mem_regwrite & reg_match(bus.ex_rt, bus.mem_rd))
      fwd_b_raw = FWD_EXMEM;
    else if (bus.wb_regwrite & reg_match(bus.ex_rt, bus.wb_rd))
      fwd_b_raw = FWD_MEMWB;
  end
`else
  // Without forwarding, wait until the producer reaches WB; the regfile
  // writes in the first half-cycle so a WB producer is already visible.
  assign stall_raw = stall_load | stall_branch | stall_mdu |
                     (bus.ex_regwrite & hit_ex) | (bus.mem_regwrite & hit_mem);
  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{bus.ex_rs, bus.ex_rt, bus.wb_rd, bus.wb_regwrite};
`endif

  assign stall = stall_raw & out_en;

  // A start that is itself stalled (or arrives while masked) is not taken.
  assign start_acc = bus.id_mdu_start & ~stall_raw & out_en;

  mdu_sequencer #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_sequencer (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_acc),
    .state_o (mdu_state)
  );

  assign bus.stall_if = stall;
  assign bus.stall_id = stall;
  assign bus.flush_ex = stall;
  // A stalled branch re-resolves next cycle, so its redirect waits too.
  assign bus.flush_id = (|bus.id_pcsrc) & ~stall_raw & out_en;
  assign bus.fwd_a    = out_en ? fwd_a_raw : FWD_RF;
  assign bus.fwd_b    = out_en ? fwd_b_raw : FWD_RF;
  assign bus.mdu_busy = mdu_busy_raw & out_en;

endmodule
